// File: rtl/ita_requant_out_fifo.sv
// Output buffer behind the requantizer: stores whole N-lane vectors and sends each one
// as N/OUT_LANES beats on a valid/ready stream. Raises stall_o early so in-flight results still fit.
module ita_requant_out_fifo #(
  parameter int N            = 16,
  parameter int WI           = 8,
  parameter int OUT_LANES    = 4,
  parameter int DEPTH        = 4,
  parameter int STALL_MARGIN = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     valid_i,
  input  logic [N*WI-1:0]          data_i,
  output logic                     stall_o,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [OUT_LANES*WI-1:0]  data_o,
  output logic                     last_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     overflow_o
);

  localparam int BEATS = N / OUT_LANES;
  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = PW + 1;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int SW    = OUT_LANES * WI;

  localparam logic [CW-1:0] FULL_LVL  = CW'(DEPTH);
  localparam logic [CW-1:0] STALL_LVL = CW'(DEPTH - STALL_MARGIN);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  logic [N*WI-1:0] r_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic [BW-1:0]   r_beat;
  logic            r_overflow;

  logic            w_valid;
  logic            w_xfer;
  logic            w_pop_last;
  logic            w_space;
  logic            w_push;
  logic            w_drop;
  logic [N*WI-1:0] w_head;
  logic [SW-1:0]   w_beat_data;
  logic [CW-1:0]   w_count_nxt;
  logic [BW-1:0]   w_beat_nxt;
  logic [PW-1:0]   w_wr_ptr_nxt;
  logic [PW-1:0]   w_rd_ptr_nxt;

  assign w_valid    = (r_count != '0);
  assign w_xfer     = w_valid && ready_i;
  assign w_pop_last = w_xfer && (r_beat == LAST_BEAT);
  // A full buffer still accepts a vector when the head entry leaves on the same edge.
  assign w_space    = (r_count < FULL_LVL) || w_pop_last;
  assign w_push     = valid_i && w_space;
  assign w_drop     = valid_i && !w_space;
  assign w_head     = r_mem[r_rd_ptr];

  // Next-state computation for pointers, occupancy and beat position
  always_comb begin
    w_count_nxt  = r_count;
    w_beat_nxt   = r_beat;
    w_wr_ptr_nxt = r_wr_ptr;
    w_rd_ptr_nxt = r_rd_ptr;

    case ({w_push, w_pop_last})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase

    if (w_push) begin
      w_wr_ptr_nxt = r_wr_ptr + PW'(1);
    end else begin
      w_wr_ptr_nxt = r_wr_ptr;
    end

    if (w_pop_last) begin
      w_beat_nxt   = '0;
      w_rd_ptr_nxt = r_rd_ptr + PW'(1);
    end else if (w_xfer) begin
      w_beat_nxt   = r_beat + BW'(1);
      w_rd_ptr_nxt = r_rd_ptr;
    end else begin
      w_beat_nxt   = r_beat;
      w_rd_ptr_nxt = r_rd_ptr;
    end
  end

  // Control state registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_beat     <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_wr_ptr   <= w_wr_ptr_nxt;
      r_rd_ptr   <= w_rd_ptr_nxt;
      r_count    <= w_count_nxt;
      r_beat     <= w_beat_nxt;
      r_overflow <= r_overflow || w_drop;
    end
  end

  // Vector storage; contents are only meaningful below the occupancy count
  always_ff @(posedge clk_i) begin
    if (w_push && !rst_i) begin
      r_mem[r_wr_ptr] <= data_i;
    end else begin
      r_mem[r_wr_ptr] <= r_mem[r_wr_ptr];
    end
  end

  // Beat selection from the head entry as an AND-OR mux
  always_comb begin
    w_beat_data = '0;
    for (int b = 0; b < BEATS; b++) begin
      w_beat_data = w_beat_data |
                    ((r_beat == BW'(b)) ? w_head[b*SW +: SW] : {SW{1'b0}});
    end
  end

  assign valid_o    = w_valid;
  assign data_o     = w_valid ? w_beat_data : '0;
  assign last_o     = w_valid && (r_beat == LAST_BEAT);
  assign count_o    = r_count;
  assign stall_o    = (r_count >= STALL_LVL);
  assign overflow_o = r_overflow;

endmodule

// File: tb/tb_ita_requant_out_fifo.sv
// Self-checking bench: queue-of-vectors reference model plus a beat reassembly scoreboard.
module tb_ita_requant_out_fifo;

  localparam int N     = 16;
  localparam int WI    = 8;
  localparam int OL    = 4;
  localparam int DEPTH = 4;
  localparam int SM    = 2;
  localparam int BEATS = N / OL;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int VW    = N * WI;
  localparam int SW    = OL * WI;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          valid_i;
  logic [VW-1:0] data_i;
  logic          stall_o;
  logic          valid_o;
  logic          ready_i;
  logic [SW-1:0] data_o;
  logic          last_o;
  logic [CW-1:0] count_o;
  logic          overflow_o;

  ita_requant_out_fifo #(
    .N(N), .WI(WI), .OUT_LANES(OL), .DEPTH(DEPTH), .STALL_MARGIN(SM)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .data_i(data_i),
    .stall_o(stall_o), .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o),
    .last_o(last_o), .count_o(count_o), .overflow_o(overflow_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  logic [VW-1:0] mq[$];
  int            mbeat   = 0;
  bit            movf    = 1'b0;
  logic [VW-1:0] asm_vec = '0;
  int            obeat   = 0;
  int            nvec_out = 0;
  bit            hold_prev = 1'b0;
  logic [SW-1:0] prev_data = '0;
  logic          prev_last = 1'b0;

  task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] v;
    for (int i = 0; i < VW / 32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  // Compare DUT against the model for the current cycle, then advance one clock.
  task automatic cycle();
    logic [VW-1:0] head;
    logic [SW-1:0] ed;
    bit            ev;
    bit            el;
    bit            xfer;
    bit            pop_last;
    bit            space;
    ev   = (mq.size() != 0);
    head = ev ? mq[0] : '0;
    ed   = ev ? head[mbeat*SW +: SW] : '0;
    el   = ev && (mbeat == BEATS - 1);
    chk("valid_o", valid_o, ev);
    chk("data_o", data_o, ed);
    chk("last_o", last_o, el);
    chk("count_o", count_o, mq.size());
    chk("stall_o", stall_o, mq.size() >= DEPTH - SM);
    chk("overflow_o", overflow_o, movf);
    if (hold_prev) begin
      chk("hold_data", data_o, prev_data);
      chk("hold_last", last_o, prev_last);
    end
    hold_prev = !rst_i && valid_o && !ready_i;
    prev_data = data_o;
    prev_last = last_o;

    if (!rst_i && valid_o && ready_i) begin
      asm_vec[obeat*SW +: SW] = data_o;
      if (last_o) begin
        chk("sb_vector", asm_vec, head);
        nvec_out++;
        obeat = 0;
      end else begin
        obeat++;
      end
    end

    if (rst_i) begin
      mq.delete();
      mbeat = 0;
      movf  = 1'b0;
      obeat = 0;
    end else begin
      xfer     = ev && ready_i;
      pop_last = xfer && (mbeat == BEATS - 1);
      space    = (mq.size() < DEPTH) || pop_last;
      if (pop_last) begin
        void'(mq.pop_front());
        mbeat = 0;
      end else if (xfer) begin
        mbeat++;
      end
      if (valid_i) begin
        if (space) mq.push_back(data_i);
        else       movf = 1'b1;
      end
    end
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b0;
    cycle();
    rst_i = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    valid_i = 1'b0; ready_i = 1'b1; n = 0;
    while (mq.size() != 0 && n < budget) begin
      cycle();
      n++;
    end
    chk("drain_timeout", n < budget, 1'b1);
  endtask

  logic [31:0]   t1exp [4];
  logic [VW-1:0] v;
  int            pushed;
  int            base;
  int            n;

  initial begin
    t1exp[0] = 32'h03020100; t1exp[1] = 32'h07060504;
    t1exp[2] = 32'h0B0A0908; t1exp[3] = 32'h0F0E0D0C;
    rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b0; data_i = '0;
    @(posedge clk_i);
    @(negedge clk_i);
    cycle();
    rst_i = 1'b0;

    // T1: lane ramp, four beats
    for (int i = 0; i < N; i++) data_i[i*WI +: WI] = 8'(i);
    valid_i = 1'b1; ready_i = 1'b1;
    cycle();
    valid_i = 1'b0;
    for (int b = 0; b < 4; b++) begin
      chk("t1_valid", valid_o, 1'b1);
      chk("t1_beat", data_o, t1exp[b]);
      chk("t1_last", last_o, b == 3);
      cycle();
    end
    chk("t1_idle", valid_o, 1'b0);

    // T2: fill, stall threshold, overflow, ordered drain
    ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      data_i = rand_vec(); valid_i = 1'b1;
      cycle();
      chk("t2_stall", stall_o, (i + 1) >= DEPTH - SM);
    end
    chk("t2_count", count_o, 4);
    data_i = rand_vec();
    cycle();
    valid_i = 1'b0;
    chk("t2_overflow", overflow_o, 1'b1);
    chk("t2_count_full", count_o, 4);
    base = nvec_out;
    drain(40);
    chk("t2_vectors", nvec_out - base, 4);
    chk("t2_ovf_sticky", overflow_o, 1'b1);
    do_reset();

    // T3: push on full while the head's last beat leaves
    ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      data_i = rand_vec(); valid_i = 1'b1;
      cycle();
    end
    valid_i = 1'b0; ready_i = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    chk("t3_at_last", last_o, 1'b1);
    data_i = rand_vec(); valid_i = 1'b1;
    cycle();
    valid_i = 1'b0;
    chk("t3_count", count_o, 4);
    chk("t3_no_ovf", overflow_o, 1'b0);
    drain(40);

    // T4: random backpressure, 100 vectors
    base = nvec_out; pushed = 0; n = 0;
    while ((pushed < 100 || mq.size() != 0) && n < 5000) begin
      ready_i = ($urandom_range(1, 0) == 1);
      valid_i = (pushed < 100) && !stall_o && ($urandom_range(1, 0) == 1);
      data_i  = rand_vec();
      if (valid_i) pushed++;
      cycle();
      n++;
    end
    valid_i = 1'b0;
    chk("t4_timeout", n < 5000, 1'b1);
    chk("t4_vectors", nvec_out - base, 100);
    chk("t4_no_ovf", overflow_o, 1'b0);

    // T5: reset in the middle of a vector
    ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      data_i = rand_vec(); valid_i = 1'b1;
      cycle();
    end
    valid_i = 1'b0; ready_i = 1'b1;
    cycle();
    rst_i = 1'b1;
    cycle();
    rst_i = 1'b0;
    chk("t5_valid", valid_o, 1'b0);
    chk("t5_count", count_o, 0);
    chk("t5_ovf", overflow_o, 1'b0);
    v = rand_vec(); data_i = v; valid_i = 1'b1; ready_i = 1'b0;
    cycle();
    valid_i = 1'b0;
    chk("t5_beat0", data_o, v[SW-1:0]);
    chk("t5_not_last", last_o, 1'b0);
    drain(20);

    // T6: 3*DEPTH+1 vectors through the ring
    base = nvec_out; pushed = 0; n = 0; ready_i = 1'b1;
    while ((pushed < 3 * DEPTH + 1 || mq.size() != 0) && n < 1000) begin
      valid_i = (pushed < 3 * DEPTH + 1) && !stall_o;
      data_i  = rand_vec();
      if (valid_i) pushed++;
      cycle();
      n++;
    end
    valid_i = 1'b0;
    chk("t6_timeout", n < 1000, 1'b1);
    chk("t6_vectors", nvec_out - base, 3 * DEPTH + 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
